// File: rtl/score_disp_pkg.sv
// rtl/score_disp_pkg.sv - shared constants, converter states and 7-segment encoder
package score_disp_pkg;

    localparam int         DIGITS    = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is blank.
    function automatic logic [6:0] seg7_enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble, one bit per clk, two BCD digits out
module bin2bcd_seq #(
    parameter int SCORE_W = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [7:0]         bcd
);
    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] r_bin;
    logic [7:0]         r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         w_adj;

    // Input is pre-saturated to <=99, so the hundreds bit shifted out of the tens nibble is always 0.
    always_comb begin
        w_adj = r_bcd;
        if (r_bcd[3:0] >= 4'd5) w_adj[3:0] = r_bcd[3:0] + 4'd3;
        if (r_bcd[7:4] >= 4'd5) w_adj[7:4] = r_bcd[7:4] + 4'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_bin  <= bin;
                r_bcd  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                r_cnt          <= r_cnt + 1'b1;
                if (r_cnt == CNT_W'(SCORE_W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: rtl/score_display_scanner.sv
// rtl/score_display_scanner.sv - saturate two scores, convert to BCD, scan four 7-seg digits
module score_display_scanner
    import score_disp_pkg::*;
#(
    parameter int SCORE_W     = 7,
    parameter int SCORE_MAX   = 99,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score_l,
    input  logic [SCORE_W-1:0] score_r,
    output logic [6:0]         seg,
    output logic [3:0]         an,
    output logic               dp
);
    localparam int                 REF_W = $clog2(REFRESH_DIV);
    localparam int                 IDX_W = $clog2(DIGITS);
    localparam logic [SCORE_W-1:0] SAT   = SCORE_W'(SCORE_MAX);

    conv_state_t        r_state;
    logic               r_pending;
    logic [SCORE_W-1:0] r_snap_l, r_snap_r;
    logic [7:0]         r_bcd_l, r_bcd_r;
    logic [REF_W-1:0]   r_ref_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;
    logic               r_dp;

    logic [SCORE_W-1:0] w_sat_l, w_sat_r;
    logic               w_changed, w_start, w_tick;
    logic               w_busy_l, w_busy_r, w_done_l, w_done_r;
    logic [7:0]         w_bcd_l, w_bcd_r;
    logic [3:0]         w_digit, w_an;
    logic               w_is_tens, w_dp;
    logic [6:0]         w_seg;

    assign w_sat_l   = (score_l > SAT) ? SAT : score_l;
    assign w_sat_r   = (score_r > SAT) ? SAT : score_r;
    assign w_changed = (w_sat_l != r_snap_l) || (w_sat_r != r_snap_r);
    // The converters are kicked on the IDLE->LOAD edge, together with the snapshot.
    assign w_start   = (r_state == ST_IDLE) && (r_pending || w_changed);
    assign w_tick    = (r_ref_cnt == REF_W'(REFRESH_DIV - 1));

    bin2bcd_seq #(.SCORE_W(SCORE_W)) u_conv_l (
        .clk(clk), .reset(reset), .start(w_start), .bin(w_sat_l),
        .busy(w_busy_l), .done(w_done_l), .bcd(w_bcd_l)
    );

    bin2bcd_seq #(.SCORE_W(SCORE_W)) u_conv_r (
        .clk(clk), .reset(reset), .start(w_start), .bin(w_sat_r),
        .busy(w_busy_r), .done(w_done_r), .bcd(w_bcd_r)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b1;
            r_snap_l  <= '0;
            r_snap_r  <= '0;
            r_bcd_l   <= '0;
            r_bcd_r   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start) begin
                    r_snap_l <= w_sat_l;
                    r_snap_r <= w_sat_r;
                    r_state  <= ST_LOAD;
                end
                ST_LOAD:  r_state <= ST_SHIFT;
                ST_SHIFT: if (w_done_l && w_done_r && !(w_busy_l || w_busy_r)) r_state <= ST_DONE;
                default: begin
                    r_bcd_l   <= w_bcd_l;
                    r_bcd_r   <= w_bcd_r;
                    r_pending <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref_cnt <= '0;
            r_idx     <= '0;
        end else if (w_tick) begin
            r_ref_cnt <= '0;
            r_idx     <= r_idx + 1'b1;
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    always_comb begin
        w_digit   = r_bcd_r[3:0];
        w_is_tens = 1'b0;
        w_an      = 4'b1110;
        w_dp      = 1'b1;
        case (r_idx)
            2'd0: w_an = 4'b1110;
            2'd1: begin w_digit = r_bcd_r[7:4]; w_is_tens = 1'b1; w_an = 4'b1101; end
            2'd2: begin w_digit = r_bcd_l[3:0]; w_an = 4'b1011; w_dp = 1'b0; end
            default: begin w_digit = r_bcd_l[7:4]; w_is_tens = 1'b1; w_an = 4'b0111; end
        endcase
        w_seg = (w_is_tens && (LZ_BLANK != 0) && (w_digit == 4'd0)) ? SEG_BLANK : seg7_enc(w_digit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'hF;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
            r_dp  <= w_dp;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = r_dp;

endmodule
